// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcode, ALU and writeback encodings plus the ID/EX bundle shared by the decode stage.
package rv32i_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
    localparam logic [31:0] MRET_INSTR  = 32'h3020_0073;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        alu_op_e         alu_op;
        logic            alu_src_a;
        logic            alu_src_b;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [1:0]      wb_sel;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [2:0]      funct3;
        logic            csr_en;
        logic [11:0]     csr_addr;
        logic            ecall;
        logic            mret;
        logic            illegal;
    } idex_t;
    // alt is funct7[5]; it picks SUB only for register-register ops but SRA for both forms.
    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            3'b000:  return (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32x32 register file, two async read ports with write-through, x0 hardwired to zero.
module rv32i_regfile
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0) regs_d[wa] = wd;
    end
    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end
    assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : regs_q[ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, register read, load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [31:0]     if_instr,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            load_use_stall,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_pc4,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src_a,
    output logic            ex_alu_src_b,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic [1:0]      ex_wb_sel,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic [2:0]      ex_funct3,
    output logic            ex_csr_en,
    output logic [11:0]     ex_csr_addr,
    output logic            ex_ecall,
    output logic            ex_mret,
    output logic            ex_illegal
);
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            rs1_used, rs2_used;
    idex_t           dec, idex_d, idex_q;
    assign opc = if_instr[6:0];
    assign f3  = if_instr[14:12];
    assign f7  = if_instr[31:25];
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    rv32i_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_wdata),
        .ra1 (rs1),
        .rd1 (rs1_data),
        .ra2 (rs2),
        .rd2 (rs2_data)
    );
    always_comb begin
        dec          = '0;
        dec.pc       = if_pc;
        dec.pc4      = if_pc4;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.funct3   = f3;
        dec.csr_addr = if_instr[31:20];
        dec.imm      = imm_i;
        case (opc)
            OPC_LUI: begin
                dec.imm = imm_u; dec.alu_op = ALU_PASS_B; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm = imm_u; dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.imm = imm_j; dec.jump = 1'b1; dec.reg_write = 1'b1; dec.wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                dec.alu_src_b = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1; dec.reg_write = 1'b1; dec.wb_sel = WB_PC4;
            end
            OPC_BRANCH: begin
                dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_src_b = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.wb_sel = WB_MEM;
            end
            OPC_STORE: begin
                dec.imm = imm_s; dec.alu_src_b = 1'b1; dec.mem_write = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op = alu_sel(f3, f7[5], 1'b0); dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
            end
            OPC_OP: begin
                if (f7 == 7'h00 || f7 == 7'h20) begin
                    dec.alu_op = alu_sel(f3, f7[5], 1'b1); dec.reg_write = 1'b1;
                end else dec.illegal = 1'b1;
            end
            OPC_MISC: ;
            OPC_SYSTEM: begin
                if (if_instr == ECALL_INSTR) dec.ecall = 1'b1;
                else if (if_instr == MRET_INSTR) dec.mret = 1'b1;
                else if (f3 != 3'b000) begin
                    dec.csr_en = 1'b1; dec.reg_write = 1'b1; dec.wb_sel = WB_CSR;
                end else dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Only writers expose rd, so the forwarding unit never sees imm bits as a destination.
        dec.rd = dec.reg_write ? if_instr[11:7] : 5'd0;
    end
    assign rs1_used = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    assign rs2_used = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
    assign load_use_stall = !rst && !flush && idex_q.mem_read && idex_q.rd != 5'd0 &&
                            ((rs1_used && rs1 == idex_q.rd) || (rs2_used && rs2 == idex_q.rd));
    assign idex_d = flush ? '0 : stall ? idex_q : load_use_stall ? '0 : dec;
    always_ff @(posedge clk) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end
    assign ex_pc        = idex_q.pc;
    assign ex_pc4       = idex_q.pc4;
    assign ex_rs1_data  = idex_q.rs1_data;
    assign ex_rs2_data  = idex_q.rs2_data;
    assign ex_imm       = idex_q.imm;
    assign ex_rs1       = idex_q.rs1;
    assign ex_rs2       = idex_q.rs2;
    assign ex_rd        = idex_q.rd;
    assign ex_alu_op    = idex_q.alu_op;
    assign ex_alu_src_a = idex_q.alu_src_a;
    assign ex_alu_src_b = idex_q.alu_src_b;
    assign ex_mem_read  = idex_q.mem_read;
    assign ex_mem_write = idex_q.mem_write;
    assign ex_reg_write = idex_q.reg_write;
    assign ex_wb_sel    = idex_q.wb_sel;
    assign ex_branch    = idex_q.branch;
    assign ex_jump      = idex_q.jump;
    assign ex_jalr      = idex_q.jalr;
    assign ex_funct3    = idex_q.funct3;
    assign ex_csr_en    = idex_q.csr_en;
    assign ex_csr_addr  = idex_q.csr_addr;
    assign ex_ecall     = idex_q.ecall;
    assign ex_mret      = idex_q.mret;
    assign ex_illegal   = idex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed decode/hazard sequence with a scoreboard of expected ID/EX fields.
module tb_id_stage;
    import rv32i_pkg::*;
    logic        clk = 1'b0;
    logic        rst, stall, flush, wb_we;
    logic [31:0] if_pc, if_pc4, if_instr, wb_wdata;
    logic [4:0]  wb_rd;
    logic        load_use_stall;
    logic [31:0] ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src_a, ex_alu_src_b, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [1:0]  ex_wb_sel;
    logic        ex_branch, ex_jump, ex_jalr;
    logic [2:0]  ex_funct3;
    logic        ex_csr_en;
    logic [11:0] ex_csr_addr;
    logic        ex_ecall, ex_mret, ex_illegal;
    logic [207:0] ex_bus;
    int errors = 0;
    int checks = 0;
    id_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .load_use_stall(load_use_stall),
        .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_wb_sel(ex_wb_sel), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_funct3(ex_funct3), .ex_csr_en(ex_csr_en), .ex_csr_addr(ex_csr_addr),
        .ex_ecall(ex_ecall), .ex_mret(ex_mret), .ex_illegal(ex_illegal)
    );
    always #5 clk = ~clk;
    assign ex_bus = {ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                     ex_alu_op, ex_alu_src_a, ex_alu_src_b, ex_mem_read, ex_mem_write, ex_reg_write,
                     ex_wb_sel, ex_branch, ex_jump, ex_jalr, ex_funct3, ex_csr_en, ex_csr_addr,
                     ex_ecall, ex_mret, ex_illegal};
    localparam int S_BUS = 0, S_PC = 1, S_RS1D = 2, S_RS2D = 3, S_IMM = 4, S_RD = 5, S_ALU = 6,
                   S_SRCB = 7, S_MR = 8, S_MW = 9, S_RW = 10, S_WB = 11, S_BR = 12, S_JMP = 13,
                   S_CSR = 14, S_CADDR = 15, S_ECALL = 16, S_MRET = 17, S_ILL = 18;
    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];
    function automatic logic [31:0] obs(input int s);
        case (s)
            S_BUS:   return {31'b0, |ex_bus};
            S_PC:    return ex_pc;
            S_RS1D:  return ex_rs1_data;
            S_RS2D:  return ex_rs2_data;
            S_IMM:   return ex_imm;
            S_RD:    return {27'b0, ex_rd};
            S_ALU:   return {28'b0, ex_alu_op};
            S_SRCB:  return {31'b0, ex_alu_src_b};
            S_MR:    return {31'b0, ex_mem_read};
            S_MW:    return {31'b0, ex_mem_write};
            S_RW:    return {31'b0, ex_reg_write};
            S_WB:    return {30'b0, ex_wb_sel};
            S_BR:    return {31'b0, ex_branch};
            S_JMP:   return {31'b0, ex_jump};
            S_CSR:   return {31'b0, ex_csr_en};
            S_CADDR: return {20'b0, ex_csr_addr};
            S_ECALL: return {31'b0, ex_ecall};
            S_MRET:  return {31'b0, ex_mret};
            S_ILL:   return {31'b0, ex_illegal};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask
    task automatic push(input string tag, input int sel, input logic [31:0] e);
        sbq.push_back('{tag, sel, e});
    endtask
    task automatic step();
        sb_t t;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            t = sbq.pop_front();
            chk(t.tag, obs(t.sel), t.exp);
        end
    endtask
    task automatic settle_lus(input string tag, input logic e);
        #1;
        chk(tag, {31'b0, load_use_stall}, {31'b0, e});
    endtask
    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_wdata = '0;
        if_pc = 32'h100; if_pc4 = 32'h104; if_instr = 32'h00500093;
        step();
        push("rst_bus", S_BUS, 0);
        step();
        chk("rst_lus", {31'b0, load_use_stall}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if_instr = {12'b0, i[4:0], 3'b000, 5'd1, 7'h33};
            push("rf_clr", S_RS1D, 0);
            step();
        end
        if_instr = 32'h00500093;
        push("addi_pc", S_PC, 32'h100);
        push("addi_rd", S_RD, 1);
        push("addi_imm", S_IMM, 5);
        push("addi_alu", S_ALU, 32'(ALU_ADD));
        push("addi_srcb", S_SRCB, 1);
        push("addi_rw", S_RW, 1);
        push("addi_wb", S_WB, 0);
        step();
        wb_we = 1'b1; wb_rd = 5'd5; wb_wdata = 32'hDEADBEEF; if_instr = 32'h00528333;
        push("wt_rs1", S_RS1D, 32'hDEADBEEF);
        push("wt_rs2", S_RS2D, 32'hDEADBEEF);
        step();
        wb_we = 1'b0;
        push("stored_rs1", S_RS1D, 32'hDEADBEEF);
        step();
        if_instr = 32'h0000A103;
        push("lw_mr", S_MR, 1);
        push("lw_rd", S_RD, 2);
        push("lw_wb", S_WB, 32'(WB_MEM));
        step();
        if_instr = 32'h002101B3;
        settle_lus("lu_stall", 1'b1);
        push("lu_bubble", S_BUS, 0);
        step();
        chk("lu_one_cycle", {31'b0, load_use_stall}, 32'd0);
        push("lu_issue_rd", S_RD, 3);
        push("lu_issue_rw", S_RW, 1);
        step();
        if_instr = 32'h0000A003;
        step();
        if_instr = 32'h000001B3;
        settle_lus("lu_x0", 1'b0);
        if_instr = 32'h0000A103;
        step();
        flush = 1'b1; if_instr = 32'h002101B3;
        settle_lus("lu_flush_gate", 1'b0);
        push("flush_bubble", S_BUS, 0);
        step();
        flush = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd0; wb_wdata = 32'h1234; if_instr = 32'h000003B3;
        push("x0_wt", S_RS1D, 0);
        step();
        wb_we = 1'b0;
        push("x0_read", S_RS1D, 0);
        step();
        flush = 1'b1; stall = 1'b1; if_instr = 32'h00500093;
        push("flush_stall", S_BUS, 0);
        step();
        flush = 1'b0; stall = 1'b0; if_instr = 32'h0000007F;
        push("ill_flag", S_ILL, 1);
        push("ill_rw", S_RW, 0);
        push("ill_mr", S_MR, 0);
        step();
        if_instr = 32'h023100B3;
        push("op_f7_ill", S_ILL, 1);
        push("op_f7_rw", S_RW, 0);
        step();
        if_instr = 32'h30200073;
        push("mret", S_MRET, 1);
        push("mret_ill", S_ILL, 0);
        step();
        if_instr = 32'h00000073;
        push("ecall", S_ECALL, 1);
        step();
        if_instr = 32'h305110F3;
        push("csr_en", S_CSR, 1);
        push("csr_addr", S_CADDR, 32'h305);
        push("csr_wb", S_WB, 32'(WB_CSR));
        push("csr_rd", S_RD, 1);
        step();
        stall = 1'b1; if_instr = 32'h00500093;
        push("stall_hold_csr", S_CSR, 1);
        push("stall_hold_rd", S_RD, 1);
        push("stall_hold_imm", S_IMM, 32'h305);
        step();
        stall = 1'b0; if_instr = 32'h403100B3;
        push("sub_alu", S_ALU, 32'(ALU_SUB));
        step();
        if_instr = 32'h40315093;
        push("srai_alu", S_ALU, 32'(ALU_SRA));
        step();
        if_instr = 32'h123450B7;
        push("lui_imm", S_IMM, 32'h12345000);
        push("lui_alu", S_ALU, 32'(ALU_PASS_B));
        step();
        if_instr = 32'hFE208EE3;
        push("beq_imm", S_IMM, 32'hFFFFFFFC);
        push("beq_br", S_BR, 1);
        push("beq_rw", S_RW, 0);
        step();
        if_instr = 32'h008000EF;
        push("jal_imm", S_IMM, 8);
        push("jal_jmp", S_JMP, 1);
        push("jal_wb", S_WB, 32'(WB_PC4));
        step();
        if_instr = 32'hFE20AC23;
        push("sw_imm", S_IMM, 32'hFFFFFFF8);
        push("sw_mw", S_MW, 1);
        step();
        if_instr = 32'h0000000F;
        push("fence_nop", S_RW, 0);
        push("fence_ill", S_ILL, 0);
        step();
        wb_we = 1'b1; wb_rd = 5'd5; wb_wdata = 32'hCAFE0001;
        step();
        wb_we = 1'b0; rst = 1'b1; if_instr = 32'h00500093;
        push("midrst_bus", S_BUS, 0);
        step();
        rst = 1'b0;
        push("postrst_rd", S_RD, 1);
        push("postrst_imm", S_IMM, 5);
        step();
        if_instr = 32'h00528333;
        push("postrst_rf", S_RS1D, 0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
